m_conv_mac_1: RTL
=================

# m_conv_mac_1

Convolution multiply-accumulate stage placed directly downstream of the layer-1 input windowing buffer. Consumes the 16-bit signed pixel stream emitted in kernel-window order (KERNEL_TAPS consecutive samples per output pixel). For each window it computes the fixed-point dot product with a locally held weight set, adds a bias, applies ReLU with saturation, and emits one 16-bit feature-map pixel per window. It also flags the end of each output map.

## Interface
- KERNEL_TAPS, 16: samples per window (4x4 kernel); 2..16.
- FRAC_BITS, 8: fractional bits of the Q-format shared by pixels, weights and bias.
- OUT_COUNT, 484: output pixels per map (22x22).
- clk_in  in  1: clock.
- rst_n  in  1: synchronous, active-low reset.
- in_valid  in  1: map_in is valid this cycle. Driven by the inverted upstream ready.
- map_in  in  16: signed pixel, Q(15-FRAC_BITS).FRAC_BITS.
- w_wr  in  1: weight write strobe.
- w_addr  in  4: weight tap index.
- w_data  in  16: signed weight.
- b_wr  in  1: bias write strobe.
- b_data  in  16: signed bias, same Q-format.
- map_out  out  16: signed result; always >= 0.
- out_valid  out  1: one-cycle pulse; map_out is valid.
- map_done  out  1: one-cycle pulse coincident with the last out_valid of a map.

## Operation
- **Weight and bias storage**
  - Holds KERNEL_TAPS x 16-bit weight registers plus one 16-bit bias register.
  - Writes take effect on the clock edge where w_wr or b_wr is high.
  - Storage is not cleared by rst_n; power-up value is 0.
  - w_addr >= KERNEL_TAPS: write ignored.
- **Tap counter**
  - tap_cnt advances only on cycles with in_valid=1.
  - Wraps from KERNEL_TAPS-1 to 0.
  - tap_cnt==0 marks the first sample of a window; KERNEL_TAPS-1 marks the last.
  - Gaps with in_valid=0 may occur anywhere, including mid-window; the window resumes where it left off.
- **Pipeline**, each stage qualified by a valid bit carried with first/last flags:
  - S1: register map_in and weight[tap_cnt].
  - S2: 32-bit signed product.
  - S3: update 36-bit signed accumulator.
    - First tap: acc = sext(bias)<<FRAC_BITS + prod.
    - Otherwise: acc = acc + prod.
    - No overflow is possible within the 36-bit width.
  - S4: apply only on the last tap.
    - r = acc >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
    - map_out = 0 if r<0; 32767 if r>32767; else r[15:0].
    - Assert out_valid for one cycle.
- **Output counter**
  - Increments on each out_valid.
  - On out_valid with count==OUT_COUNT-1: assert map_done and wrap the count to 0.
- **Write/read collision:** if w_wr targets the tap being read in the same cycle, S1 captures the old weight. Weights are loaded while in_valid is idle.
- **Reset (rst_n=0 at a clock edge)** clears:
  - tap_cnt and the output counter;
  - all pipeline valid bits and the accumulator;
  - map_out=0, out_valid=0, map_done=0.
  - A partially accumulated window is discarded.
  - Samples presented during reset are ignored.

## Timing
- Reset values: map_out=0, out_valid=0, map_done=0.
- Latency: last tap accepted at edge T gives out_valid=1 and map_out valid in the cycle after edge T+4.
- Throughput: one sample per clock, no backpressure. Back-to-back windows yield out_valid every KERNEL_TAPS cycles.
- The first tap of window n+1 may immediately follow the last tap of window n. The accumulator reload at the first tap needs no bubble.
- map_out holds its value between pulses.

## Test plan
- Load all weights 256 (1.0), bias 0; stream 16 samples of 256 → one out_valid, map_out=4096, 4 cycles after the last sample.
- Weights -256, bias 0, samples 256 → map_out=0 (ReLU). Weights and samples 32767 → map_out=32767 (saturation).
- Samples 0, bias 0x0180 → map_out=384. Weights 256, samples 1..16 (raw), bias 0 → sum 136·256>>8 = map_out=136.
- in_valid toggled 1/0 randomly over 3 windows of constant 256 → exactly 3 pulses, each 4096, each 4 cycles after that window's 16th valid sample.
- rst_n low for 1 cycle after 8 taps, then 16 taps of 256 → single out_valid with 4096; weights survive the reset.
- OUT_COUNT=4, 5 back-to-back windows → map_done only with the 4th out_valid; the 5th starts a new map count.

Source files
------------

// File: rtl/m_conv_mac_1.sv
// Convolution MAC stage: per-window dot product of the pixel stream with local weights,
// plus bias, then ReLU and saturation to a 16-bit feature-map pixel.
module m_conv_mac_1 #(
    parameter int KERNEL_TAPS = 16,
    parameter int FRAC_BITS   = 8,
    parameter int OUT_COUNT   = 484
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] map_in,
    input  logic        w_wr,
    input  logic [3:0]  w_addr,
    input  logic [15:0] w_data,
    input  logic        b_wr,
    input  logic [15:0] b_data,
    output logic [15:0] map_out,
    output logic        out_valid,
    output logic        map_done
);
    localparam int TAP_W = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;
    localparam int CNT_W = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
    localparam logic [4:0]       TAPS     = 5'(KERNEL_TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(OUT_COUNT - 1);

    logic signed [15:0] weight [KERNEL_TAPS];
    logic signed [15:0] bias;

    // NOTE: coefficient storage has no reset branch; it must survive rst_n, and leaving
    // it out of the reset keeps it a plain register file rather than resettable flops.
    always_ff @(posedge clk_in) begin
        if (w_wr && ({1'b0, w_addr} < TAPS))
            weight[w_addr[TAP_W-1:0]] <= w_data;
        if (b_wr)
            bias <= b_data;
    end

    logic [TAP_W-1:0]   tap_cnt;
    logic               s1_v, s1_first, s1_last;
    logic signed [15:0] s1_pix, s1_w;
    logic               s2_v, s2_first, s2_last;
    logic signed [31:0] s2_prod;
    logic               s3_v;
    logic signed [35:0] acc;
    logic               s4_v;
    logic [15:0]        s4_res;
    logic [CNT_W-1:0]   out_cnt;

    logic signed [35:0] bias_ext, prod_ext, acc_shr;
    logic [15:0]        sat;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bias_ext = {{20{bias[15]}}, bias} <<< FRAC_BITS;
        prod_ext = {{4{s2_prod[31]}}, s2_prod};
        acc_shr  = acc >>> FRAC_BITS;
        sat      = acc_shr[15:0];
        if (acc_shr < 36'sd0)
            sat = 16'd0;
        else if (acc_shr > 36'sd32767)
            sat = 16'h7fff;
    end

    // NOTE: sequential state uses non-blocking assignments so each stage reads the
    // previous stage's pre-edge value, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            tap_cnt   <= '0;
            s1_v      <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_pix    <= '0;
            s1_w      <= '0;
            s2_v      <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_prod   <= '0;
            s3_v      <= 1'b0;
            acc       <= '0;
            s4_v      <= 1'b0;
            s4_res    <= '0;
            out_cnt   <= '0;
            map_out   <= '0;
            out_valid <= 1'b0;
            map_done  <= 1'b0;
        end else begin
            if (in_valid)
                tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + 1'b1;

            // Reading the weight here with NBA semantics gives the old value on a collision.
            s1_v     <= in_valid;
            s1_first <= (tap_cnt == '0);
            s1_last  <= (tap_cnt == LAST_TAP);
            s1_pix   <= map_in;
            s1_w     <= weight[tap_cnt];

            s2_v     <= s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_prod  <= s1_pix * s1_w;

            s3_v <= s2_v && s2_last;
            if (s2_v)
                acc <= s2_first ? bias_ext + prod_ext : acc + prod_ext;

            s4_v   <= s3_v;
            s4_res <= sat;

            out_valid <= s4_v;
            map_done  <= 1'b0;
            if (s4_v) begin
                map_out <= s4_res;
                if (out_cnt == LAST_OUT) begin
                    map_done <= 1'b1;
                    out_cnt  <= '0;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
        end
    end
endmodule
